// File: rtl/prefetch_queue_if.sv
// Bundle between the instruction prefetcher and its environment: control-transfer load,
// decoder-side byte FIFO read port and the instruction-port memory bus.
interface prefetch_queue_if;
  logic        load_new_ip;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [18:0] mem_address;
  logic        mem_access;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport master (
    input  load_new_ip, new_cs, new_ip, fifo_rd_en, mem_ack, mem_data,
    output fifo_rd_data, fifo_empty, fifo_full, mem_address, mem_access
  );

  modport slave (
    output load_new_ip, new_cs, new_ip, fifo_rd_en, mem_ack, mem_data,
    input  fifo_rd_data, fifo_empty, fifo_full, mem_address, mem_access
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: fetches 16-bit words at CS:IP into a byte FIFO ahead of the decoder,
// flushing and restarting on a control transfer.
module prefetch_queue #(
  parameter int unsigned QUEUE_BYTES = 6,
  parameter logic [15:0] RESET_CS    = 16'hFFFF,
  parameter logic [15:0] RESET_IP    = 16'h0000
) (
  input logic              clk,
  input logic              reset,
  prefetch_queue_if.master bus
);

  localparam int unsigned     PtrW     = $clog2(QUEUE_BYTES);
  localparam int unsigned     CntW     = $clog2(QUEUE_BYTES + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(QUEUE_BYTES - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_BYTES);
  localparam logic [19:0]     ResetPhys = {RESET_CS, 4'h0} + {4'h0, RESET_IP};

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [18:0] phys_word(input logic [15:0] cs, input logic [15:0] ip);
    logic [19:0] sum;
    sum = {cs, 4'h0} + {4'h0, ip};
    return sum[19:1];
  endfunction

  state_e          state_q, state_d;
  logic            access_q, access_d;
  logic            abort_q, abort_d;
  logic [18:0]     addr_q, addr_d;
  logic [15:0]     cs_q, cs_d;
  logic [15:0]     ip_q, ip_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [QUEUE_BYTES];

  logic            we0, we1;
  logic [PtrW-1:0] waddr0, waddr1;
  logic [7:0]      wdata0, wdata1;
  logic [CntW-1:0] free;
  logic [1:0]      n_push;
  logic            ack_take, push_ok, pop;

  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    abort_d  = abort_q;
    cs_d     = cs_q;
    ip_d     = ip_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    we0      = 1'b0;
    we1      = 1'b0;
    waddr0   = wr_ptr_q;
    waddr1   = ptr_inc(wr_ptr_q);
    wdata0   = bus.mem_data[7:0];
    wdata1   = bus.mem_data[15:8];
    n_push   = 2'd0;

    free     = DepthCnt - count_q;
    ack_take = (state_q == StFetch) && bus.mem_ack;
    // An aborted word, or one landing with a new load, is dropped on the floor.
    push_ok  = ack_take && !abort_q && !bus.load_new_ip;
    pop      = bus.fifo_rd_en && (count_q != '0) && !bus.load_new_ip;

    unique case (state_q)
      StIdle: begin
        if (!bus.load_new_ip &&
            ((ip_q[0] && free != '0) || (!ip_q[0] && free >= CntW'(2)))) begin
          state_d  = StFetch;
          access_d = 1'b1;
        end
      end
      StFetch: begin
        if (bus.mem_ack) begin
          state_d  = StIdle;
          access_d = 1'b0;
          abort_d  = 1'b0;
        end else if (bus.load_new_ip) begin
          abort_d = 1'b1;
        end
      end
    endcase

    if (push_ok) begin
      if (ip_q[0]) begin
        we0      = 1'b1;
        wdata0   = bus.mem_data[15:8];
        wr_ptr_d = ptr_inc(wr_ptr_q);
        ip_d     = ip_q + 16'd1;
        n_push   = 2'd1;
      end else begin
        we0      = 1'b1;
        we1      = 1'b1;
        wr_ptr_d = ptr_inc(ptr_inc(wr_ptr_q));
        ip_d     = ip_q + 16'd2;
        n_push   = 2'd2;
      end
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CntW'(n_push) - CntW'(pop);

    if (bus.load_new_ip) begin
      cs_d     = bus.new_cs;
      ip_d     = bus.new_ip;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    // Address is frozen for the whole access; otherwise it tracks the next fetch pointer.
    addr_d = (state_q == StFetch && state_d == StFetch) ? addr_q : phys_word(cs_d, ip_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      access_q <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= ResetPhys[19:1];
      cs_q     <= RESET_CS;
      ip_q     <= RESET_IP;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      abort_q  <= abort_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      ip_q     <= ip_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < QUEUE_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
    end
  end

  assign bus.fifo_empty   = (count_q == '0);
  assign bus.fifo_full    = (count_q == DepthCnt);
  assign bus.fifo_rd_data = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.mem_access   = access_q;
  assign bus.mem_address  = addr_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus randomized traffic against a queue-based
// reference model of the prefetcher.
module tb_prefetch_queue;
  localparam int QB = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prefetch_queue_if bus ();

  prefetch_queue #(
    .QUEUE_BYTES(QB),
    .RESET_CS   (16'hFFFF),
    .RESET_IP   (16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic [15:0] m_cs, m_ip;
  bit          m_busy, m_abort;
  logic [18:0] m_addr;

  function automatic logic [18:0] phys(input logic [15:0] cs, input logic [15:0] ip);
    logic [31:0] p;
    p = (32'(cs) * 32'd16 + 32'(ip)) % 32'h0010_0000;
    return p[19:1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cs = 16'hFFFF;
    m_ip = 16'h0000;
    m_busy = 0;
    m_abort = 0;
    m_addr = phys(m_cs, m_ip);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return at edge+1.
  task automatic cycle(input bit load, input logic [15:0] ncs, input logic [15:0] nip,
                       input bit rd, input bit ack, input logic [15:0] data);
    int free;
    bus.load_new_ip = load;
    bus.new_cs      = ncs;
    bus.new_ip      = nip;
    bus.fifo_rd_en  = rd;
    bus.mem_ack     = ack;
    bus.mem_data    = data;
    free = QB - m_q.size();
    if (rd && m_q.size() > 0 && !load) void'(m_q.pop_front());
    if (m_busy && ack) begin
      if (!m_abort && !load) begin
        if (m_ip[0]) begin
          m_q.push_back(data[15:8]);
          m_ip = m_ip + 16'd1;
        end else begin
          m_q.push_back(data[7:0]);
          m_q.push_back(data[15:8]);
          m_ip = m_ip + 16'd2;
        end
      end
      m_busy = 0;
      m_abort = 0;
    end else if (m_busy && load) begin
      m_abort = 1;
    end else if (!m_busy && !load && (m_ip[0] ? free >= 1 : free >= 2)) begin
      m_busy = 1;
      m_addr = phys(m_cs, m_ip);
    end
    if (load) begin
      m_q.delete();
      m_cs = ncs;
      m_ip = nip;
    end
    @(posedge clk);
    #1;
    bus.load_new_ip = 1'b0;
    bus.fifo_rd_en  = 1'b0;
    bus.mem_ack     = 1'b0;
  endtask

  task automatic idle();
    cycle(0, 16'h0, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic wait_access(output logic [18:0] addr, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_access === 1'b1) begin
        ok = 1;
        break;
      end
      idle();
    end
    addr = bus.mem_address;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_access: mem_access=%b after 20 cycles, required 1", bus.mem_access);
    end
  endtask

  task automatic ack_fetch(input logic [15:0] data, output logic [18:0] addr);
    bit ok;
    wait_access(addr, ok);
    if (ok) cycle(0, 16'h0, 16'h0, 0, 1, data);
  endtask

  task automatic restart(input logic [15:0] cs, input logic [15:0] ip);
    logic [18:0] a;
    cycle(1, cs, ip, 0, 0, 16'h0);
    if (m_busy) ack_fetch(16'hC0DE, a);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_new_ip = 0; bus.new_cs = 0; bus.new_ip = 0;
    bus.fifo_rd_en = 0; bus.mem_ack = 0; bus.mem_data = 0;
    model_reset();
    #12;
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); end
    checks++; if (bus.fifo_full !== 1'b0) begin errors++;
      $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
    checks++; if (bus.fifo_rd_data !== 8'h00) begin errors++;
      $display("FAIL reset_rd_data: got %h want 00", bus.fifo_rd_data); end
    checks++; if (bus.mem_access !== 1'b0) begin errors++;
      $display("FAIL reset_access: got %b want 0", bus.mem_access); end
    checks++; if (bus.mem_address !== 19'h7FFF8) begin errors++;
      $display("FAIL reset_addr: got %h want 7fff8", bus.mem_address); end
    #6;
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    logic [18:0] a;
    ack_fetch(16'hBBAA, a);
    checks++; if (a !== 19'h7FFF8) begin errors++;
      $display("FAIL t1_addr: got %h want 7fff8", a); end
    checks++; if (bus.fifo_rd_data !== 8'hAA) begin errors++;
      $display("FAIL t1_byte0: got %h want aa", bus.fifo_rd_data); end
    cycle(0, 16'h0, 16'h0, 1, 0, 16'h0);
    checks++; if (bus.fifo_rd_data !== 8'hBB) begin errors++;
      $display("FAIL t1_byte1: got %h want bb", bus.fifo_rd_data); end
    cycle(0, 16'h0, 16'h0, 1, 0, 16'h0);
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL t1_empty: got %b want 1", bus.fifo_empty); end
    ack_fetch(16'h2211, a);
    checks++; if (a !== 19'h7FFF9) begin errors++;
      $display("FAIL t1_next_addr: got %h want 7fff9", a); end
  endtask

  task automatic test_odd_load();
    logic [18:0] a;
    bit ok;
    restart(16'h1000, 16'h0003);
    ack_fetch(16'h3412, a);
    checks++; if (a !== 19'h08001) begin errors++;
      $display("FAIL t2_addr: got %h want 08001", a); end
    checks++; if (bus.fifo_rd_data !== 8'h34) begin errors++;
      $display("FAIL t2_byte: got %h want 34", bus.fifo_rd_data); end
    cycle(0, 16'h0, 16'h0, 1, 0, 16'h0);
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL t2_single_byte: empty got %b want 1", bus.fifo_empty); end
    wait_access(a, ok);
    checks++; if (a !== 19'h08002) begin errors++;
      $display("FAIL t2_next_addr: got %h want 08002", a); end
  endtask

  task automatic test_fill();
    logic [18:0] a;
    bit ok;
    bit seen;
    restart(16'h2000, 16'h0000);
    ack_fetch(16'h0100, a);
    ack_fetch(16'h0302, a);
    ack_fetch(16'h0504, a);
    checks++; if (bus.fifo_full !== 1'b1) begin errors++;
      $display("FAIL t3_full: got %b want 1", bus.fifo_full); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (bus.mem_access !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++;
      $display("FAIL t3_no_fetch_full: mem_access seen 1 while full, want 0"); end
    checks++; if (bus.fifo_rd_data !== 8'h00) begin errors++;
      $display("FAIL t3_order0: got %h want 00", bus.fifo_rd_data); end
    cycle(0, 16'h0, 16'h0, 1, 0, 16'h0);
    idle();
    idle();
    checks++; if (bus.mem_access !== 1'b0) begin errors++;
      $display("FAIL t3_one_free: mem_access got %b want 0", bus.mem_access); end
    checks++; if (bus.fifo_rd_data !== 8'h01) begin errors++;
      $display("FAIL t3_order1: got %h want 01", bus.fifo_rd_data); end
    cycle(0, 16'h0, 16'h0, 1, 0, 16'h0);
    wait_access(a, ok);
    checks++; if (a !== 19'h10003) begin errors++;
      $display("FAIL t3_resume_addr: got %h want 10003", a); end
  endtask

  task automatic test_abort();
    logic [18:0] a;
    bit ok;
    restart(16'h3000, 16'h0000);
    wait_access(a, ok);
    checks++; if (a !== 19'h18000) begin errors++;
      $display("FAIL t4_addr: got %h want 18000", a); end
    cycle(1, 16'h4000, 16'h0000, 0, 0, 16'h0);
    checks++; if (bus.mem_access !== 1'b1 || bus.mem_address !== 19'h18000) begin errors++;
      $display("FAIL t4_held: access=%b addr=%h want 1 18000", bus.mem_access, bus.mem_address);
    end
    idle();
    checks++; if (bus.mem_access !== 1'b1) begin errors++;
      $display("FAIL t4_held2: access got %b want 1", bus.mem_access); end
    cycle(0, 16'h0, 16'h0, 0, 1, 16'hDEAD);
    checks++; if (bus.fifo_empty !== 1'b1 || bus.mem_access !== 1'b0) begin errors++;
      $display("FAIL t4_discard: empty=%b access=%b want 1 0", bus.fifo_empty, bus.mem_access);
    end
    wait_access(a, ok);
    checks++; if (a !== 19'h20000) begin errors++;
      $display("FAIL t4_new_addr: got %h want 20000", a); end
  endtask

  task automatic test_wrap();
    logic [18:0] a;
    bit ok;
    restart(16'h0000, 16'hFFFE);
    ack_fetch(16'h7766, a);
    checks++; if (a !== 19'h07FFF) begin errors++;
      $display("FAIL t5_addr: got %h want 07fff", a); end
    wait_access(a, ok);
    checks++; if (a !== 19'h00000) begin errors++;
      $display("FAIL t5_ip_wrap: got %h want 00000", a); end
    restart(16'hFFFF, 16'h0010);
    ack_fetch(16'h9988, a);
    checks++; if (a !== 19'h00000) begin errors++;
      $display("FAIL t5_phys_wrap: got %h want 00000", a); end
    checks++; if (bus.fifo_rd_data !== 8'h88) begin errors++;
      $display("FAIL t5_byte: got %h want 88", bus.fifo_rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [18:0] a;
    bit ok;
    logic [7:0] exp;
    restart(16'h5000, 16'h0000);
    ack_fetch(16'h1110, a);
    ack_fetch(16'h1312, a);
    wait_access(a, ok);
    cycle(0, 16'h0, 16'h0, 1, 1, 16'h1514);
    checks++; if (bus.fifo_empty !== 1'b0 || bus.fifo_full !== 1'b0) begin errors++;
      $display("FAIL t6_flags: empty=%b full=%b want 0 0", bus.fifo_empty, bus.fifo_full); end
    for (int i = 0; i < 5; i++) begin
      exp = 8'h11 + 8'(i);
      checks++; if (bus.fifo_rd_data !== exp) begin errors++;
        $display("FAIL t6_order%0d: got %h want %h", i, bus.fifo_rd_data, exp); end
      cycle(0, 16'h0, 16'h0, 1, 0, 16'h0);
    end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL t6_count: empty got %b want 1 after 5 pops", bus.fifo_empty); end
  endtask

  task automatic test_random();
    restart(16'h1234, 16'h0101);
    for (int i = 0; i < 1500; i++) begin
      bit ld, rd, ak;
      checks++; if (bus.mem_access !== m_busy) begin errors++;
        $display("FAIL rnd_access@%0d: got %b want %b", i, bus.mem_access, m_busy); end
      checks++; if (bus.fifo_empty !== (m_q.size() == 0)) begin errors++;
        $display("FAIL rnd_empty@%0d: got %b want %b", i, bus.fifo_empty, m_q.size() == 0); end
      checks++; if (bus.fifo_full !== (m_q.size() == QB)) begin errors++;
        $display("FAIL rnd_full@%0d: got %b want %b", i, bus.fifo_full, m_q.size() == QB); end
      if (m_q.size() > 0) begin
        checks++; if (bus.fifo_rd_data !== m_q[0]) begin errors++;
          $display("FAIL rnd_data@%0d: got %h want %h", i, bus.fifo_rd_data, m_q[0]); end
      end
      if (m_busy) begin
        checks++; if (bus.mem_address !== m_addr) begin errors++;
          $display("FAIL rnd_addr@%0d: got %h want %h", i, bus.mem_address, m_addr); end
      end
      ld = ($urandom_range(0, 24) == 0);
      rd = ($urandom_range(0, 1) == 1);
      ak = m_busy && ($urandom_range(0, 2) == 0);
      cycle(ld, 16'($urandom), 16'($urandom), rd, ak, 16'($urandom));
    end
  endtask

  task automatic test_async_reset();
    logic [18:0] a;
    #3;
    reset = 1'b1;
    #2;
    model_reset();
    checks++; if (bus.fifo_empty !== 1'b1 || bus.mem_access !== 1'b0) begin errors++;
      $display("FAIL async_reset: empty=%b access=%b want 1 0", bus.fifo_empty, bus.mem_access);
    end
    reset = 1'b0;
    ack_fetch(16'h4321, a);
    checks++; if (a !== 19'h7FFF8 || bus.fifo_rd_data !== 8'h21) begin errors++;
      $display("FAIL async_restart: addr=%h byte=%h want 7fff8 21", a, bus.fifo_rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_odd_load();
    test_fill();
    test_abort();
    test_wrap();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
